spfp_seq_multiplier: RTL and testbench

Multi-cycle IEEE-754 single-precision multiplier with valid/ready handshakes: the forward operation that the team's Newton-Raphson divider inverts. It computes the 48-bit mantissa product by radix-2 shift-and-add, one bit per clock, rather than with a flat array multiplier. It sits beside the combinational SPFP arithmetic in the neural-network datapath, where layer MAC sequencing trades throughput for area.

---
 rtl/spfp_pkg.sv | 23 ++
 rtl/spfp_mant_seq_mul.sv | 67 ++++++
 rtl/spfp_seq_multiplier.sv | 171 +++++++++++++++++
 tb/tb_spfp_seq_multiplier.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/spfp_pkg.sv
// Shared single-precision (binary32) definitions.
//
// Holds the format constants and the handshake FSM state type used by the
// sequential SPFP arithmetic blocks (multiplier today; divider and adder
// variants later).
package spfp_pkg;

    localparam int          SPFP_BIAS    = 127;
    localparam logic [7:0]  SPFP_EXP_MAX = 8'hFF;
    localparam int          SPFP_MANT_W  = 23;

    // Significand with the hidden bit, and the full double-width product.
    localparam int          SPFP_SIG_W   = SPFP_MANT_W + 1;
    localparam int          SPFP_PROD_W  = 2 * SPFP_SIG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } spfp_state_e;

endpackage : spfp_pkg

// File: rtl/spfp_mant_seq_mul.sv
// Radix-2 shift-and-add significand multiplier, one multiplier bit per clock.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   start    load mant_a/mant_b, clear the accumulator, restart the counter
//   mant_a   24-bit multiplicand significand (hidden bit included)
//   mant_b   24-bit multiplier significand (hidden bit included)
//   done     high from the edge that performs the last partial-product add
//            until the next start
//   product  48-bit accumulated product (final once done is high)
module spfp_mant_seq_mul
    import spfp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [SPFP_SIG_W-1:0]  mant_a,
    input  logic [SPFP_SIG_W-1:0]  mant_b,
    output logic                   done,
    output logic [SPFP_PROD_W-1:0] product
);

    localparam logic [4:0] LAST_BIT = 5'(SPFP_SIG_W - 1);

    logic [SPFP_SIG_W-1:0]  ma_q;
    logic [SPFP_SIG_W-1:0]  mb_q;
    logic [SPFP_PROD_W-1:0] acc_q;
    logic [4:0]             cnt_q;
    logic                   busy_q;
    logic                   done_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ma_q   <= '0;
            mb_q   <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start) begin
            ma_q   <= mant_a;
            mb_q   <= mant_b;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            // Partial product for multiplier bit cnt is mant_a weighted by 2^cnt.
            if (mb_q[cnt_q]) begin
                acc_q <= acc_q + ({{SPFP_SIG_W{1'b0}}, ma_q} << cnt_q);
            end
            if (cnt_q == LAST_BIT) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule : spfp_mant_seq_mul

// File: rtl/spfp_seq_multiplier.sv
// Multi-cycle IEEE-754 binary32 multiplier with valid/ready handshakes.
//
// The significand product is built by spfp_mant_seq_mul (one bit per clock);
// this level owns the handshake FSM, exponent path, normalization (truncating)
// and special-case resolution. Denormal inputs are flushed to zero.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operands a/b valid
//   in_ready   operands can be accepted (IDLE only)
//   a, b       binary32 operands, sampled on the accepting edge
//   out_valid  res and flags valid, held until out_ready
//   out_ready  consumer accepts the result
//   res        binary32 product
//   exception  an operand had exponent 8'hFF
//   overflow   biased result exponent >= 255
//   underflow  biased result exponent <= 0 with non-zero operands
module spfp_seq_multiplier
    import spfp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        exception,
    output logic        overflow,
    output logic        underflow
);

    localparam logic signed [9:0] BIAS_S    = 10'(SPFP_BIAS);
    localparam logic signed [9:0] EXP_LIMIT = 10'sd255;

    spfp_state_e state_q, state_nxt;

    logic        accept;
    logic [31:0] a_q, b_q;
    logic        mul_done;
    logic [SPFP_PROD_W-1:0] product;

    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Significand engine: loaded directly from the inputs on the accepting
    // edge, so its 24 add steps land on the following 24 edges.
    // ------------------------------------------------------------------
    spfp_mant_seq_mul u_mant_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .mant_a  ({1'b1, a[SPFP_MANT_W-1:0]}),
        .mant_b  ({1'b1, b[SPFP_MANT_W-1:0]}),
        .done    (mul_done),
        .product (product)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE: if (accept)    state_nxt = MULT;
            MULT: if (mul_done)  state_nxt = NORM;
            NORM:                state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Sign and exponent fields are needed again in NORM; keep the operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    // ------------------------------------------------------------------
    // Normalization and special cases (evaluated while in NORM)
    // ------------------------------------------------------------------
    logic                   sign;
    logic [7:0]             ea, eb;
    logic signed [9:0]      exp_sum, exp_adj;
    logic [SPFP_MANT_W-1:0] mant_n;
    logic [31:0]            norm_res;
    logic                   norm_exc, norm_ovf, norm_unf;

    always_comb begin
        sign = a_q[31] ^ b_q[31];
        ea   = a_q[30:23];
        eb   = b_q[30:23];

        // 10-bit signed keeps both the overflow (up to 384) and the
        // underflow (down to -127) range representable.
        exp_sum = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;

        // Product of two [1,2) significands lies in [1,4): a set top bit
        // means one extra binade.
        if (product[SPFP_PROD_W-1]) begin
            mant_n  = product[SPFP_PROD_W-2 -: SPFP_MANT_W];
            exp_adj = exp_sum + 10'sd1;
        end else begin
            mant_n  = product[SPFP_PROD_W-3 -: SPFP_MANT_W];
            exp_adj = exp_sum;
        end

        norm_exc = 1'b0;
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        if (ea == SPFP_EXP_MAX || eb == SPFP_EXP_MAX) begin
            norm_res = {sign, SPFP_EXP_MAX, {SPFP_MANT_W{1'b0}}};
            norm_exc = 1'b1;
        end else if (ea == 8'h00 || eb == 8'h00) begin
            norm_res = {sign, 31'h0};
        end else if (exp_adj >= EXP_LIMIT) begin
            norm_res = {sign, SPFP_EXP_MAX, {SPFP_MANT_W{1'b0}}};
            norm_ovf = 1'b1;
        end else if (exp_adj <= 10'sd0) begin
            norm_res = {sign, 31'h0};
            norm_unf = 1'b1;
        end else begin
            norm_res = {sign, exp_adj[7:0], mant_n};
        end
    end

    // Result registers: written once in NORM, frozen through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res       <= '0;
            exception <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (state_q == NORM) begin
            res       <= norm_res;
            exception <= norm_exc;
            overflow  <= norm_ovf;
            underflow <= norm_unf;
        end
    end

endmodule : spfp_seq_multiplier

// File: tb/tb_spfp_seq_multiplier.sv
// Self-checking bench for spfp_seq_multiplier: directed vector table,
// randomized operands against a behavioural binary32 model, plus hand-written
// back-pressure and mid-operation reset sequences.
module tb_spfp_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] res;
    logic        exception, overflow, underflow;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spfp_seq_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .exception (exception),
        .overflow  (overflow),
        .underflow (underflow)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flags;   // {exception, overflow, underflow}
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
    } ref_t;

    // Behavioural binary32 product: integer significand multiply, truncation,
    // flush-to-zero and saturation to infinity.
    function automatic ref_t ref_mul(input logic [31:0] x, input logic [31:0] y);
        ref_t   r;
        int     ex, ey, e;
        longint sx, sy, p, frac;
        logic   s;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        r.flags = 3'b000;
        if (ex == 255 || ey == 255) begin
            r.res   = {s, 8'hFF, 23'h0};
            r.flags = 3'b100;
        end else if (ex == 0 || ey == 0) begin
            r.res = {s, 31'h0};
        end else begin
            sx = longint'(x[22:0]) + 64'd8388608;
            sy = longint'(y[22:0]) + 64'd8388608;
            p  = sx * sy;
            e  = ex + ey - 127;
            if (p >= (64'd1 << 47)) begin
                frac = (p >> 24) & 64'h7F_FFFF;
                e    = e + 1;
            end else begin
                frac = (p >> 23) & 64'h7F_FFFF;
            end
            if (e >= 255) begin
                r.res   = {s, 8'hFF, 23'h0};
                r.flags = 3'b010;
            end else if (e <= 0) begin
                r.res   = {s, 31'h0};
                r.flags = 3'b001;
            end else begin
                r.res = {s, 8'(e), 23'(frac)};
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one operand pair and return just after the accepting edge.
    task automatic send(input logic [31:0] xa, input logic [31:0] xb);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;   // operands need only be held to the accepting edge
        b        = $urandom;
    endtask

    // Count edges from the accept until out_valid is seen (sampled on negedge).
    task automatic wait_valid(output int lat);
        lat = 0;
        forever begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
            if (lat >= 100) begin
                check("out_valid_timeout", 32'(out_valid), 32'd1);
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] exp_res, input logic [2:0] exp_flags,
                          input bit chk_lat);
        int lat;
        out_ready = 1'b1;
        send(xa, xb);
        wait_valid(lat);
        if (chk_lat) check({name, "_latency"}, 32'(lat), 32'd26);
        check({name, "_res"}, res, exp_res);
        check({name, "_flags"}, {29'd0, exception, overflow, underflow}, {29'd0, exp_flags});
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[7];

    initial begin
        ref_t        r;
        logic [31:0] xa, xb, held;
        int          lat, seen;

        vecs[0] = '{"mul_2x3",      32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b000};
        vecs[1] = '{"mul_1p5sq",    32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 3'b000};
        vecs[2] = '{"mul_neg2xhalf",32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 3'b000};
        vecs[3] = '{"mul_zero",     32'h0000_0000, 32'hC200_0000, 32'h8000_0000, 3'b000};
        vecs[4] = '{"mul_ovf",      32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b010};
        vecs[5] = '{"mul_inf",      32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 3'b100};
        vecs[6] = '{"mul_unf",      32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b001};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_res",       res,            32'd0);
        check("rst_flags", {29'd0, exception, overflow, underflow}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags, 1'b1);

        // Random operands; odd iterations pull exponents toward the normal range.
        for (int i = 0; i < 30; i++) begin
            xa = $urandom;
            xb = $urandom;
            if (i % 2 == 1) begin
                xa[30:23] = 8'(90 + $urandom_range(0, 80));
                xb[30:23] = 8'(90 + $urandom_range(0, 80));
            end
            r = ref_mul(xa, xb);
            run_op($sformatf("rand%0d", i), xa, xb, r.res, r.flags, i < 3);
        end

        // Back-pressure: result held 10 cycles, in_valid ignored meanwhile.
        out_ready = 1'b0;
        send(32'h3F80_0000, 32'h4000_0000);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd26);
        held = res;
        check("bp_res", held, 32'h4000_0000);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = 32'h4040_0000;
            b        = 32'h4040_0000;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold_ready%0d", i), 32'(in_ready),  32'd0);
            check($sformatf("bp_hold_res%0d", i),   res,            held);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready),  32'd1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp_no_extra_result", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of MULT.
        send(32'h4040_0000, 32'h4000_0000);
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready",  32'(in_ready),  32'd1);
        check("mrst_res",       res,            32'd0);
        check("mrst_flags", {29'd0, exception, overflow, underflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst_1x1", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_spfp_seq_multiplier
